// File: rtl/spike_time_decoder_if.sv
// rtl/spike_time_decoder_if.sv - result port of the spike time decoder
// Carries the decoded time vector and spike mask with its valid/ready handshake.
interface spike_time_decoder_if #(
  parameter int N = 4,
  parameter int W = 4
);
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] times;
  logic [N-1:0]   spiked;

  modport master (output out_valid, output times, output spiked, input out_ready);
  modport slave  (input out_valid, input times, input spiked, output out_ready);
endinterface

// File: rtl/spike_time_decoder.sv
// rtl/spike_time_decoder.sv - temporal lane to binary time-stamp decoder
// Measures each lane's first 1->0 fall inside a gamma window and offers the result.
module spike_time_decoder #(
  parameter int N          = 4,
  parameter int W          = 4,
  parameter bit EARLY_DONE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N-1:0]            lines,
  output logic                    busy,
  spike_time_decoder_if.master    res
);

  typedef enum logic [1:0] {IDLE, WINDOW, DONE} state_t;

  localparam logic [W-1:0] T_MAX = {W{1'b1}};

  state_t         state;
  logic [W-1:0]   counter;
  logic [N*W-1:0] times_q;
  logic [N-1:0]   spiked_q;
  logic [N-1:0]   prev_q;
  logic           busy_q;
  logic           valid_q;

  logic [N-1:0]   capture;
  logic [N-1:0]   spiked_next;
  logic [N*W-1:0] times_next;
  logic           window_end;

  // Lanes still uncaptured when the window closes saturate to T_MAX.
  always_comb begin
    capture     = prev_q & ~lines & ~spiked_q;
    spiked_next = spiked_q | capture;
    window_end  = (counter == T_MAX) || (EARLY_DONE && (&spiked_next));
    times_next  = times_q;
    for (int i = 0; i < N; i++) begin
      if (capture[i]) begin
        times_next[i*W +: W] = counter;
      end else if (window_end && !spiked_next[i]) begin
        times_next[i*W +: W] = T_MAX;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      counter  <= '0;
      times_q  <= '0;
      spiked_q <= '0;
      prev_q   <= '1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= WINDOW;
            busy_q   <= 1'b1;
            counter  <= '0;
            times_q  <= '0;
            spiked_q <= '0;
            prev_q   <= '1;
          end
        end
        WINDOW: begin
          prev_q   <= lines;
          spiked_q <= spiked_next;
          times_q  <= times_next;
          if (window_end) begin
            state   <= DONE;
            valid_q <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        DONE: begin
          if (res.out_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign res.out_valid = valid_q;
  assign res.times     = times_q;
  assign res.spiked    = spiked_q;

endmodule
